// File: rtl/uart_rx_cfg_pkg.sv
// Shared definitions for the configurable UART receiver: parity codes, FSM
// state encoding and the oversample tick divider computation.
package uart_rx_cfg_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // Rounded clocks-per-tick, never below 1.
  function automatic int calc_div(input int sys_clock, input int baud, input int os);
    longint den;
    longint q;
    den = longint'(baud) * longint'(os);
    q   = (longint'(sys_clock) + den / 2) / den;
    return (q < 1) ? 1 : int'(q);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_baud_tick.sv
// Free-running oversample tick generator: a one-cycle pulse every DIV clocks.
module uart_baud_tick
  import uart_rx_cfg_pkg::*;
#(
  parameter int SYS_CLOCK     = 50000000,
  parameter int UART_BAUDRATE = 115200,
  parameter int OVERSAMPLE    = 16
) (
  input  logic i_SysClock,
  input  logic i_Reset,
  output logic o_Tick
);

  localparam int DIV = calc_div(SYS_CLOCK, UART_BAUDRATE, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_Cnt;

  always_ff @(posedge i_SysClock) begin
    if (i_Reset) begin
      r_Cnt <= '0;
    end else if (r_Cnt == LAST) begin
      r_Cnt <= '0;
    end else begin
      r_Cnt <= r_Cnt + CW'(1);
    end
  end

  assign o_Tick = (r_Cnt == LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5-9 data bits, optional parity, 1-2 stop bits,
// 3-sample majority vote around mid-bit, valid/ready output with overrun flag.
module uart_rx_cfg
  import uart_rx_cfg_pkg::*;
#(
  parameter int SYS_CLOCK     = 50000000,
  parameter int UART_BAUDRATE = 115200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int OVERSAMPLE    = 16
) (
  input  logic                 i_SysClock,
  input  logic                 i_Reset,
  input  logic                 i_RxSerial,
  output logic [DATA_BITS-1:0] o_RxByte,
  output logic                 o_RxValid,
  input  logic                 i_RxReady,
  output logic                 o_ParityErr,
  output logic                 o_FrameErr,
  output logic                 o_Overrun,
  output logic                 o_Busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] VOTE_IDX = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] DB_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] SB_LAST  = BW'(STOP_BITS - 1);

  logic                 r_Sync1, r_Sync2;
  logic [1:0]           r_Hist;
  logic                 r_SeenHigh;
  rx_state_t            r_State;
  logic [CW-1:0]        r_Cnt;
  logic [BW-1:0]        r_BitCnt;
  logic [DATA_BITS-1:0] r_Shift;
  logic                 r_ParErrAcc, r_FrmErrAcc, r_Done;
  logic [DATA_BITS-1:0] r_RxByte;
  logic                 r_RxValid, r_ParityErr, r_FrameErr, r_Overrun;

  logic      w_Tick, w_Line, w_Maj, w_Vote, w_ParExp;
  rx_state_t w_StateNext;
  logic      w_Start, w_ShiftEn, w_ParSample, w_StopSample, w_Done;

  uart_baud_tick #(
    .SYS_CLOCK     (SYS_CLOCK),
    .UART_BAUDRATE (UART_BAUDRATE),
    .OVERSAMPLE    (OVERSAMPLE)
  ) u_tick (
    .i_SysClock (i_SysClock),
    .i_Reset    (i_Reset),
    .o_Tick     (w_Tick)
  );

  assign w_Line = r_Sync2;
  // r_Hist holds the two previous tick samples, so the vote spans three consecutive ticks.
  assign w_Maj  = (r_Hist[1] & r_Hist[0]) | (r_Hist[1] & w_Line) | (r_Hist[0] & w_Line);
  assign w_Vote = w_Tick && (r_Cnt == VOTE_IDX) && (r_State != ST_IDLE);
  assign w_ParExp = (PARITY == PARITY_ODD) ? ~(^r_Shift) : (^r_Shift);

  always_comb begin
    w_StateNext  = r_State;
    w_Start      = 1'b0;
    w_ShiftEn    = 1'b0;
    w_ParSample  = 1'b0;
    w_StopSample = 1'b0;
    w_Done       = 1'b0;
    case (r_State)
      ST_IDLE: begin
        if (w_Tick && !w_Line && r_SeenHigh) begin
          w_StateNext = ST_START;
          w_Start     = 1'b1;
        end
      end
      ST_START: begin
        if (w_Vote) w_StateNext = w_Maj ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (w_Vote) begin
          w_ShiftEn = 1'b1;
          if (r_BitCnt == DB_LAST) w_StateNext = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (w_Vote) begin
          w_ParSample = 1'b1;
          w_StateNext = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_Vote) begin
          w_StopSample = 1'b1;
          if (r_BitCnt == SB_LAST) begin
            w_StateNext = ST_IDLE;
            w_Done      = 1'b1;
          end
        end
      end
      default: w_StateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_SysClock) begin
    if (i_Reset) begin
      r_Sync1     <= 1'b1;
      r_Sync2     <= 1'b1;
      r_Hist      <= 2'b11;
      r_SeenHigh  <= 1'b0;
      r_State     <= ST_IDLE;
      r_Cnt       <= '0;
      r_BitCnt    <= '0;
      r_Shift     <= '0;
      r_ParErrAcc <= 1'b0;
      r_FrmErrAcc <= 1'b0;
      r_Done      <= 1'b0;
    end else begin
      r_Sync1 <= i_RxSerial;
      r_Sync2 <= r_Sync1;
      r_State <= w_StateNext;
      r_Done  <= w_Done;
      if (w_Tick) r_Hist <= {r_Hist[0], w_Line};
      if (w_Start) r_SeenHigh <= 1'b0;
      else if (w_Tick && w_Line) r_SeenHigh <= 1'b1;
      // The start-detect tick is sample 0, so the next tick is sample 1.
      if (w_Start) r_Cnt <= CW'(1);
      else if (w_Tick && r_State != ST_IDLE) r_Cnt <= (r_Cnt == CNT_LAST) ? '0 : r_Cnt + CW'(1);
      if (w_StateNext != r_State) r_BitCnt <= '0;
      else if (w_Vote) r_BitCnt <= r_BitCnt + BW'(1);
      if (w_ShiftEn) r_Shift <= {w_Maj, r_Shift[DATA_BITS-1:1]};
      if (w_Start) begin
        r_ParErrAcc <= 1'b0;
        r_FrmErrAcc <= 1'b0;
      end else begin
        if (w_ParSample) r_ParErrAcc <= (w_Maj != w_ParExp);
        if (w_StopSample && !w_Maj) r_FrmErrAcc <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_SysClock) begin
    if (i_Reset) begin
      r_RxByte    <= '0;
      r_RxValid   <= 1'b0;
      r_ParityErr <= 1'b0;
      r_FrameErr  <= 1'b0;
      r_Overrun   <= 1'b0;
    end else if (r_Done) begin
      if (!r_RxValid || i_RxReady) begin
        r_RxByte    <= r_Shift;
        r_ParityErr <= r_ParErrAcc;
        r_FrameErr  <= r_FrmErrAcc;
        r_RxValid   <= 1'b1;
        r_Overrun   <= 1'b0;
      end else begin
        r_Overrun   <= 1'b1;
      end
    end else if (r_RxValid && i_RxReady) begin
      r_RxValid   <= 1'b0;
      r_ParityErr <= 1'b0;
      r_FrameErr  <= 1'b0;
      r_Overrun   <= 1'b0;
    end
  end

  assign o_RxByte    = r_RxByte;
  assign o_RxValid   = r_RxValid;
  assign o_ParityErr = r_ParityErr;
  assign o_FrameErr  = r_FrameErr;
  assign o_Overrun   = r_Overrun;
  assign o_Busy      = (r_State != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance and a 7O2 instance driven with
// serial frames built from the line format, checked against expected words.
module tb_uart_rx_cfg;

  localparam int SYS_CLK  = 50000000;
  localparam int BAUD     = 446428;
  localparam int BIT_CLKS = 112;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } word_t;

  logic       clk = 1'b0;
  logic       srst;
  logic       rx8, rdy8, valid8, perr8, ferr8, ovr8, busy8;
  logic [7:0] byte8;
  logic       rx7, rdy7, valid7, perr7, ferr7, ovr7, busy7;
  logic [6:0] byte7;

  int n_vec  = 0;
  int n_miss = 0;

  word_t cap_q[2][$];
  word_t exp_q[2][$];

  always #5 clk = ~clk;

  uart_rx_cfg #(
    .SYS_CLOCK(SYS_CLK), .UART_BAUDRATE(BAUD), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)
  ) u_dut8 (
    .i_SysClock(clk), .i_Reset(srst), .i_RxSerial(rx8), .o_RxByte(byte8),
    .o_RxValid(valid8), .i_RxReady(rdy8), .o_ParityErr(perr8),
    .o_FrameErr(ferr8), .o_Overrun(ovr8), .o_Busy(busy8)
  );

  uart_rx_cfg #(
    .SYS_CLOCK(SYS_CLK), .UART_BAUDRATE(BAUD), .DATA_BITS(7),
    .PARITY(2), .STOP_BITS(2), .OVERSAMPLE(16)
  ) u_dut7 (
    .i_SysClock(clk), .i_Reset(srst), .i_RxSerial(rx7), .o_RxByte(byte7),
    .o_RxValid(valid7), .i_RxReady(rdy7), .o_ParityErr(perr7),
    .o_FrameErr(ferr7), .o_Overrun(ovr7), .o_Busy(busy7)
  );

  function automatic word_t mk(input logic [8:0] d, input logic p, input logic f, input logic o);
    return {d, p, f, o};
  endfunction

  // Words are taken on the handshake; sampled on the falling edge before the accepting edge.
  always @(negedge clk) begin
    if (!srst && valid8 && rdy8) cap_q[0].push_back(mk({1'b0, byte8}, perr8, ferr8, ovr8));
    if (!srst && valid7 && rdy7) cap_q[1].push_back(mk({2'b0, byte7}, perr7, ferr7, ovr7));
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int which, input logic b);
    if (which == 0) rx8 = b;
    else rx7 = b;
  endtask

  // Frame = start, nb data bits LSB first, optional parity, nstop stop bits.
  task automatic send(input int which, input logic [8:0] data, input int nb, input int par,
                      input bit flip_par, input int nstop, input bit stop_low);
    bit bits[$];
    int ones;
    bit pbit;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      bits.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (par != 0) begin
      pbit = (par == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
      bits.push_back(pbit ^ flip_par);
    end
    for (int i = 0; i < nstop; i++) bits.push_back(!(stop_low && i == nstop - 1));
    foreach (bits[i]) begin
      set_line(which, bits[i]);
      wait_clk(BIT_CLKS);
    end
    set_line(which, 1'b1);
  endtask

  task automatic expect_word(input int which, input logic [8:0] d, input logic p,
                             input logic f, input logic o);
    exp_q[which].push_back(mk(d, p, f, o));
  endtask

  task automatic drain(input int which, input string tag);
    int n;
    int guard;
    word_t g;
    word_t e;
    n = exp_q[which].size();
    guard = 0;
    while (cap_q[which].size() < n && guard < 4 * BIT_CLKS) begin
      wait_clk(1);
      guard++;
    end
    chk({tag, "_count"}, cap_q[which].size(), n);
    while (exp_q[which].size() > 0 && cap_q[which].size() > 0) begin
      g = cap_q[which].pop_front();
      e = exp_q[which].pop_front();
      $display("%s: rx data=0x%0h perr=%0d ferr=%0d ovr=%0d (exp data=0x%0h perr=%0d ferr=%0d ovr=%0d)",
               tag, g.data, g.perr, g.ferr, g.ovr, e.data, e.perr, e.ferr, e.ovr);
      chk({tag, "_data"}, g.data, e.data);
      chk({tag, "_perr"}, g.perr, e.perr);
      chk({tag, "_ferr"}, g.ferr, e.ferr);
      chk({tag, "_ovr"},  g.ovr,  e.ovr);
    end
    exp_q[which].delete();
    cap_q[which].delete();
  endtask

  logic [7:0] fixed8 [4];
  logic [8:0] bv;
  bit         fl;
  int         k;

  initial begin
    fixed8 = '{8'h55, 8'h00, 8'hFF, 8'hAA};
    srst = 1'b1; rx8 = 1'b1; rx7 = 1'b1; rdy8 = 1'b1; rdy7 = 1'b1;
    wait_clk(5);
    chk("rst_valid", valid8, 0);
    chk("rst_byte",  byte8, 0);
    chk("rst_perr",  perr8, 0);
    chk("rst_ferr",  ferr8, 0);
    chk("rst_ovr",   ovr8, 0);
    chk("rst_busy",  busy8, 0);
    srst = 1'b0;
    wait_clk(3 * BIT_CLKS);

    // 8N1 fixed patterns then random bytes, back to back
    for (int i = 0; i < 4; i++) begin
      send(0, {1'b0, fixed8[i]}, 8, 0, 0, 1, 0);
      expect_word(0, {1'b0, fixed8[i]}, 0, 0, 0);
    end
    for (int i = 0; i < 10; i++) begin
      bv = 9'($urandom_range(0, 255));
      send(0, bv, 8, 0, 0, 1, 0);
      expect_word(0, bv, 0, 0, 0);
    end
    wait_clk(BIT_CLKS);
    drain(0, "8n1");

    // 7O2: good parity, flipped parity, then random mix
    send(1, 9'h41, 7, 2, 0, 2, 0);
    expect_word(1, 9'h41, 0, 0, 0);
    send(1, 9'h41, 7, 2, 1, 2, 0);
    expect_word(1, 9'h41, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      bv = 9'($urandom_range(0, 127));
      fl = 1'($urandom_range(0, 1));
      send(1, bv, 7, 2, fl, 2, 0);
      expect_word(1, bv, fl, 0, 0);
    end
    wait_clk(BIT_CLKS);
    drain(1, "7o2");

    // Stop bit forced low, then a clean frame after some idle
    send(0, 9'h03C, 8, 0, 0, 1, 1);
    expect_word(0, 9'h03C, 0, 1, 0);
    wait_clk(2 * BIT_CLKS);
    chk("ferr_idle_busy", busy8, 0);
    send(0, 9'h096, 8, 0, 0, 1, 0);
    expect_word(0, 9'h096, 0, 0, 0);
    wait_clk(BIT_CLKS);
    drain(0, "ferr");

    // 40-clock low glitch on an idle line
    set_line(0, 1'b0);
    wait_clk(20);
    chk("glitch_busy", busy8, 1);
    wait_clk(20);
    set_line(0, 1'b1);
    wait_clk(BIT_CLKS - 40);
    chk("glitch_idle", busy8, 0);
    wait_clk(BIT_CLKS);
    drain(0, "glitch");

    // Overrun: consumer stalled across two frames
    rdy8 = 1'b0;
    send(0, 9'h011, 8, 0, 0, 1, 0);
    send(0, 9'h022, 8, 0, 0, 1, 0);
    wait_clk(BIT_CLKS);
    chk("ovr_valid", valid8, 1);
    chk("ovr_byte",  byte8, 8'h11);
    chk("ovr_flag",  ovr8, 1);
    rdy8 = 1'b1;
    wait_clk(1);
    chk("acc_valid", valid8, 0);
    chk("acc_ovr",   ovr8, 0);
    expect_word(0, 9'h011, 0, 0, 1);
    drain(0, "ovr");

    // Accept on the exact completion cycle of the second frame
    rdy8 = 1'b0;
    wait_clk(2 * BIT_CLKS);
    fork
      begin
        send(0, 9'h011, 8, 0, 0, 1, 0);
        send(0, 9'h022, 8, 0, 0, 1, 0);
      end
      begin
        k = 0;
        while (!valid8 && k < 20 * BIT_CLKS) begin
          wait_clk(1);
          k++;
        end
        chk("same_first_valid", valid8, 1);
        // Frames are 1120 clocks apart, a multiple of the tick period.
        wait_clk(10 * BIT_CLKS - 1);
        rdy8 = 1'b1;
        wait_clk(1);
        rdy8 = 1'b0;
        chk("same_valid", valid8, 1);
        chk("same_byte",  byte8, 8'h22);
        chk("same_ovr",   ovr8, 0);
      end
    join
    expect_word(0, 9'h011, 0, 0, 0);
    rdy8 = 1'b1;
    expect_word(0, 9'h022, 0, 0, 0);
    wait_clk(BIT_CLKS);
    drain(0, "same");

    // Reset during data bit 3 of 0xA5, line held low afterwards
    wait_clk(2 * BIT_CLKS);
    bv = 9'h0A5;
    set_line(0, 1'b0);
    wait_clk(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      set_line(0, bv[i]);
      wait_clk(BIT_CLKS);
    end
    set_line(0, bv[3]);
    wait_clk(50);
    srst = 1'b1;
    wait_clk(1);
    srst = 1'b0;
    chk("rstmid_busy",  busy8, 0);
    chk("rstmid_valid", valid8, 0);
    set_line(0, 1'b0);
    wait_clk(3 * BIT_CLKS);
    chk("rstmid_low_busy", busy8, 0);
    set_line(0, 1'b1);
    wait_clk(2 * BIT_CLKS);
    send(0, 9'h05A, 8, 0, 0, 1, 0);
    expect_word(0, 9'h05A, 0, 0, 0);
    wait_clk(BIT_CLKS);
    drain(0, "rstmid");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
